// File: rtl/reset_sequencer_if.sv
// Board reset sequencer signal bundle.
// Optional soft_reset_req is present only when RESET_SEQ_SOFT_RESET_EN is defined.
// master: the sequencer itself; slave: the board/SoC side that feeds and observes it.
interface reset_sequencer_if #(
    parameter int unsigned CNT_WIDTH = 8
);
    logic                 btn_n;
    logic                 pll_locked;
`ifdef RESET_SEQ_SOFT_RESET_EN
    logic                 soft_reset_req;
`endif
    logic                 reset;
    logic                 ready;
    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] reset_count;

`ifdef RESET_SEQ_SOFT_RESET_EN
    modport master (
        input  btn_n, pll_locked, soft_reset_req,
        output reset, ready, state, reset_count
    );
    modport slave (
        output btn_n, pll_locked, soft_reset_req,
        input  reset, ready, state, reset_count
    );
`else
    modport master (
        input  btn_n, pll_locked,
        output reset, ready, state, reset_count
    );
    modport slave (
        output btn_n, pll_locked,
        input  reset, ready, state, reset_count
    );
`endif
endinterface

// File: rtl/reset_sequencer.sv
// Board-level reset generator for mini16_soc: debounced push-button, filtered PLL lock and a
// minimum hold time gate the release of the active-high SoC reset.
// Optional feature macro RESET_SEQ_SOFT_RESET_EN adds a clk-domain soft reset request that
// only acts in RUN.
module reset_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES    = 1400000,
    parameter int unsigned HOLD_CYCLES        = 256,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH          = 8
) (
    input logic               clk,
    input logic               reset_n,
    reset_sequencer_if.master bus
);
    localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SEQ_MAX = (HOLD_CYCLES > LOCK_STABLE_CYCLES) ?
                                      HOLD_CYCLES : LOCK_STABLE_CYCLES;
    localparam int unsigned SEQ_W   = (SEQ_MAX > 1) ? $clog2(SEQ_MAX) : 1;

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SEQ_W-1:0] HOLD_LAST   = SEQ_W'(HOLD_CYCLES - 1);
    localparam logic [SEQ_W-1:0] STABLE_LAST = SEQ_W'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        StHold     = 2'd0,
        StWaitLock = 2'd1,
        StStable   = 2'd2,
        StRun      = 2'd3
    } state_e;

    logic                 btn_meta_q, btn_sync_q;
    logic                 lock_meta_q, lock_sync_q;
    logic                 btn_db_q;
    logic [DB_W-1:0]      db_cnt_q;
    state_e               state_q, state_d;
    logic [SEQ_W-1:0]     seq_cnt_q, seq_cnt_d;
    logic                 reset_q, ready_q;
    logic [CNT_WIDTH-1:0] reset_count_q, reset_count_d;
    logic                 exit_run;
    logic                 pressed;
    logic                 soft_req;

`ifdef RESET_SEQ_SOFT_RESET_EN
    assign soft_req = bus.soft_reset_req;
`else
    assign soft_req = 1'b0;
`endif

    assign pressed = ~btn_db_q;

    // Two-flop synchronizers; button resets to released, lock to unlocked.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_meta_q  <= 1'b1;
            btn_sync_q  <= 1'b1;
            lock_meta_q <= 1'b0;
            lock_sync_q <= 1'b0;
        end else begin
            btn_meta_q  <= bus.btn_n;
            btn_sync_q  <= btn_meta_q;
            lock_meta_q <= bus.pll_locked;
            lock_sync_q <= lock_meta_q;
        end
    end

    // Debounce: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_db_q <= 1'b1;
            db_cnt_q <= '0;
        end else if (btn_sync_q == btn_db_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_db_q <= btn_sync_q;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
        end
    end

    // Sequencer next state; branch order encodes press > lock loss > soft request > terminal.
    always_comb begin
        state_d   = state_q;
        seq_cnt_d = seq_cnt_q;
        exit_run  = 1'b0;
        case (state_q)
            StHold: begin
                if (pressed) begin
                    seq_cnt_d = '0;
                end else if (seq_cnt_q == HOLD_LAST) begin
                    state_d = StWaitLock;
                end else begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                end
            end
            StWaitLock: begin
                if (pressed) begin
                    state_d = StHold;
                end else if (lock_sync_q) begin
                    state_d = StStable;
                end
            end
            StStable: begin
                if (pressed) begin
                    state_d = StHold;
                end else if (!lock_sync_q) begin
                    state_d = StWaitLock;
                end else if (seq_cnt_q == STABLE_LAST) begin
                    state_d = StRun;
                end else begin
                    seq_cnt_d = seq_cnt_q + SEQ_W'(1);
                end
            end
            StRun: begin
                if (pressed || !lock_sync_q || soft_req) begin
                    state_d  = StHold;
                    exit_run = 1'b1;
                end
            end
            default: state_d = StHold;
        endcase
        // Shared counter restarts on every state change.
        if (state_d != state_q) begin
            seq_cnt_d = '0;
        end
    end

    // Saturating count of RUN exits.
    always_comb begin
        reset_count_d = reset_count_q;
        if (exit_run && (reset_count_q != {CNT_WIDTH{1'b1}})) begin
            reset_count_d = reset_count_q + CNT_WIDTH'(1);
        end
    end

    // State and outputs registered from next state so they all move on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StHold;
            seq_cnt_q     <= '0;
            reset_q       <= 1'b1;
            ready_q       <= 1'b0;
            reset_count_q <= '0;
        end else begin
            state_q       <= state_d;
            seq_cnt_q     <= seq_cnt_d;
            reset_q       <= (state_d != StRun);
            ready_q       <= (state_d == StRun);
            reset_count_q <= reset_count_d;
        end
    end

    assign bus.reset       = reset_q;
    assign bus.ready       = ready_q;
    assign bus.state       = state_q;
    assign bus.reset_count = reset_count_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with small timing parameters.
// Scenario tasks compute expected edges from the sequencing rules; soft reset checks run only
// when RESET_SEQ_SOFT_RESET_EN is defined.
module tb_reset_sequencer;
    localparam int DB    = 8;
    localparam int H     = 16;
    localparam int L     = 32;
    localparam int CW    = 2;
    localparam int LIMIT = 400;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   edge_n    = 0;
    int   exp_count = 0;

    always #5 clk = ~clk;

    reset_sequencer_if #(.CNT_WIDTH(CW)) bus ();

    reset_sequencer #(
        .DEBOUNCE_CYCLES    (DB),
        .HOLD_CYCLES        (H),
        .LOCK_STABLE_CYCLES (L),
        .CNT_WIDTH          (CW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    function automatic int sat_inc(input int c);
        return (c >= (1 << CW) - 1) ? c : c + 1;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic apply_reset(input logic lock_lvl);
        @(negedge clk);
        reset_n        = 1'b0;
        bus.btn_n      = 1'b1;
        bus.pll_locked = lock_lvl;
`ifdef RESET_SEQ_SOFT_RESET_EN
        bus.soft_reset_req = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        edge_n    = 0;
        exp_count = 0;
    endtask

    // Returns the edge index after which reset first shows lvl, or -1 on timeout.
    task automatic wait_reset_level(input logic lvl, output int at);
        at = -1;
        for (int i = 0; i < LIMIT; i++) begin
            step();
            if (bus.reset === lvl) begin
                at = edge_n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.btn_n      = 1'b1;
        bus.pll_locked = 1'b0;
`ifdef RESET_SEQ_SOFT_RESET_EN
        bus.soft_reset_req = 1'b0;
`endif
        #23;
        n_checks++; if (bus.reset !== 1'b1) begin n_fail++;
            $display("FAIL rst_reset: got %b expected 1", bus.reset); end
        n_checks++; if (bus.ready !== 1'b0) begin n_fail++;
            $display("FAIL rst_ready: got %b expected 0", bus.ready); end
        n_checks++; if (bus.state !== 2'd0) begin n_fail++;
            $display("FAIL rst_state: got %0d expected 0", bus.state); end
        n_checks++; if (bus.reset_count !== 2'd0) begin n_fail++;
            $display("FAIL rst_count: got %0d expected 0", bus.reset_count); end
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (bus.state !== 2'd0 || bus.reset !== 1'b1) begin n_fail++;
            $display("FAIL rst_hold: got state %0d reset %b expected 0/1", bus.state, bus.reset); end
    endtask

    task automatic test_power_up();
        int at;
        apply_reset(1'b1);
        wait_reset_level(1'b0, at);
        n_checks++; if (at !== H + L + 1) begin n_fail++;
            $display("FAIL pwr_release_edge: got %0d expected %0d", at, H + L + 1); end
        n_checks++; if (bus.ready !== 1'b1) begin n_fail++;
            $display("FAIL pwr_ready: got %b expected 1", bus.ready); end
        n_checks++; if (bus.state !== 2'd3) begin n_fail++;
            $display("FAIL pwr_state: got %0d expected 3", bus.state); end
        n_checks++; if (bus.reset_count !== 2'd0) begin n_fail++;
            $display("FAIL pwr_count: got %0d expected 0", bus.reset_count); end
    endtask

    task automatic test_late_lock();
        int at, t, exp_at;
        for (int it = 0; it < 4; it++) begin
            t = (it == 0) ? 100 : int'($urandom_range(1, 120));
            apply_reset(1'b0);
            repeat (t) step();
            bus.pll_locked = 1'b1;
            step();
            step();
            if (t + 2 >= H) begin
                n_checks++; if (bus.state !== 2'd1) begin n_fail++;
                    $display("FAIL late_wait_state t=%0d: got %0d expected 1", t, bus.state); end
            end
            step();
            if (t + 2 >= H) begin
                n_checks++; if (bus.state !== 2'd2) begin n_fail++;
                    $display("FAIL late_stable_state t=%0d: got %0d expected 2", t, bus.state); end
            end
            exp_at = max2(H + 1, t + 3) + L;
            wait_reset_level(1'b0, at);
            n_checks++; if (at !== exp_at) begin n_fail++;
                $display("FAIL late_release t=%0d: got %0d expected %0d", t, at, exp_at); end
        end
    endtask

    task automatic test_lock_glitch_stable();
        int at, g, w, exp_at;
        for (int it = 0; it < 3; it++) begin
            apply_reset(1'b1);
            g = (it == 0) ? 35 : int'($urandom_range(17, 40));
            w = (it == 0) ? 1 : int'($urandom_range(1, 3));
            while (edge_n < g) step();
            bus.pll_locked = 1'b0;
            repeat (w) step();
            bus.pll_locked = 1'b1;
            while (edge_n < g + 3) step();
            n_checks++; if (bus.state !== 2'd1) begin n_fail++;
                $display("FAIL glitch_stable_state g=%0d: got %0d expected 1", g, bus.state); end
            exp_at = g + w + 3 + L;
            wait_reset_level(1'b0, at);
            n_checks++; if (at !== exp_at) begin n_fail++;
                $display("FAIL glitch_stable_release g=%0d w=%0d: got %0d expected %0d",
                         g, w, at, exp_at); end
        end
    endtask

    task automatic test_lock_glitch_run();
        int at, g;
        for (int it = 0; it < 2; it++) begin
            g = edge_n + int'($urandom_range(1, 10));
            while (edge_n < g) step();
            bus.pll_locked = 1'b0;
            step();
            bus.pll_locked = 1'b1;
            wait_reset_level(1'b1, at);
            n_checks++; if (at !== g + 3) begin n_fail++;
                $display("FAIL glitch_run_rise: got %0d expected %0d", at, g + 3); end
            exp_count = sat_inc(exp_count);
            n_checks++; if (bus.reset_count !== CW'(exp_count)) begin n_fail++;
                $display("FAIL glitch_run_count: got %0d expected %0d", bus.reset_count,
                         exp_count); end
            wait_reset_level(1'b0, at);
            n_checks++; if (at !== g + 3 + H + 1 + L) begin n_fail++;
                $display("FAIL glitch_run_release: got %0d expected %0d", at, g + 4 + H + L); end
        end
    endtask

    task automatic bounce(input int n, inout int drops);
        int lo, hi;
        for (int b = 0; b < n; b++) begin
            lo = int'($urandom_range(1, DB - 1));
            hi = int'($urandom_range(1, 5));
            bus.btn_n = 1'b0;
            repeat (lo) begin step(); if (bus.ready !== 1'b1) drops++; end
            bus.btn_n = 1'b1;
            repeat (hi) begin step(); if (bus.ready !== 1'b1) drops++; end
        end
    endtask

    task automatic test_debounce();
        int at, p, q, drops;
        drops = 0;
        bounce(4, drops);
        repeat (4) begin step(); if (bus.ready !== 1'b1) drops++; end
        n_checks++; if (drops !== 0) begin n_fail++;
            $display("FAIL bounce_only_drops: got %0d expected 0", drops); end
        n_checks++; if (bus.reset_count !== CW'(exp_count)) begin n_fail++;
            $display("FAIL bounce_only_count: got %0d expected %0d", bus.reset_count,
                     exp_count); end
        drops = 0;
        bounce(2, drops);
        bus.btn_n = 1'b0;
        p = edge_n;
        wait_reset_level(1'b1, at);
        n_checks++; if (at !== p + 11) begin n_fail++;
            $display("FAIL press_rise: got %0d expected %0d", at, p + 11); end
        exp_count = sat_inc(exp_count);
        n_checks++; if (bus.reset_count !== CW'(exp_count)) begin n_fail++;
            $display("FAIL press_count: got %0d expected %0d", bus.reset_count, exp_count); end
        repeat (int'($urandom_range(0, 20))) step();
        bus.btn_n = 1'b1;
        q = edge_n;
        wait_reset_level(1'b0, at);
        n_checks++; if (at !== q + 11 + H + L) begin n_fail++;
            $display("FAIL press_release: got %0d expected %0d", at, q + 11 + H + L); end
        n_checks++; if (bus.reset_count !== CW'(exp_count)) begin n_fail++;
            $display("FAIL press_once_count: got %0d expected %0d", bus.reset_count,
                     exp_count); end
    endtask

    task automatic test_saturation();
        int at, g;
        apply_reset(1'b1);
        wait_reset_level(1'b0, at);
        for (int i = 0; i < 5; i++) begin
            g = edge_n + 2;
            while (edge_n < g) step();
            bus.pll_locked = 1'b0;
            step();
            bus.pll_locked = 1'b1;
            wait_reset_level(1'b1, at);
            exp_count = sat_inc(exp_count);
            n_checks++; if (bus.reset_count !== CW'(exp_count)) begin n_fail++;
                $display("FAIL sat_count exit=%0d: got %0d expected %0d", i + 1,
                         bus.reset_count, exp_count); end
            wait_reset_level(1'b0, at);
            n_checks++; if (at !== g + 4 + H + L) begin n_fail++;
                $display("FAIL sat_release exit=%0d: got %0d expected %0d", i + 1, at,
                         g + 4 + H + L); end
        end
        g = edge_n + 2;
        while (edge_n < g) step();
        bus.pll_locked = 1'b0;
        step();
        bus.pll_locked = 1'b1;
        wait_reset_level(1'b1, at);
        repeat (H + 1 + 10) step();
        n_checks++; if (bus.state !== 2'd2) begin n_fail++;
            $display("FAIL async_pre_state: got %0d expected 2", bus.state); end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.reset !== 1'b1 || bus.ready !== 1'b0) begin n_fail++;
            $display("FAIL async_reset_out: got reset %b ready %b expected 1/0", bus.reset,
                     bus.ready); end
        n_checks++; if (bus.state !== 2'd0) begin n_fail++;
            $display("FAIL async_state: got %0d expected 0", bus.state); end
        n_checks++; if (bus.reset_count !== 2'd0) begin n_fail++;
            $display("FAIL async_count: got %0d expected 0", bus.reset_count); end
    endtask

`ifdef RESET_SEQ_SOFT_RESET_EN
    task automatic test_soft_reset();
        int at, s, r;
        apply_reset(1'b1);
        wait_reset_level(1'b0, at);
        for (int it = 0; it < 2; it++) begin
            s = edge_n + int'($urandom_range(1, 5));
            while (edge_n < s) step();
            bus.soft_reset_req = 1'b1;
            step();
            n_checks++; if (bus.reset !== 1'b1 || bus.state !== 2'd0) begin n_fail++;
                $display("FAIL soft_rise it=%0d: got reset %b state %0d expected 1/0", it,
                         bus.reset, bus.state); end
            // Second pass holds the request through early HOLD; it must count once.
            if (it == 1) repeat (3) step();
            bus.soft_reset_req = 1'b0;
            exp_count = sat_inc(exp_count);
            wait_reset_level(1'b0, at);
            n_checks++; if (at !== s + 1 + H + 1 + L) begin n_fail++;
                $display("FAIL soft_release it=%0d: got %0d expected %0d", it, at,
                         s + 2 + H + L); end
            n_checks++; if (bus.reset_count !== CW'(exp_count)) begin n_fail++;
                $display("FAIL soft_count it=%0d: got %0d expected %0d", it, bus.reset_count,
                         exp_count); end
        end
        s = edge_n + 2;
        while (edge_n < s) step();
        bus.pll_locked = 1'b0;
        step();
        bus.pll_locked = 1'b1;
        wait_reset_level(1'b1, r);
        exp_count = sat_inc(exp_count);
        while (edge_n < r + H + 1 + 5) step();
        n_checks++; if (bus.state !== 2'd2) begin n_fail++;
            $display("FAIL soft_stable_state: got %0d expected 2", bus.state); end
        bus.soft_reset_req = 1'b1;
        step();
        bus.soft_reset_req = 1'b0;
        wait_reset_level(1'b0, at);
        n_checks++; if (at !== r + H + 1 + L) begin n_fail++;
            $display("FAIL soft_stable_release: got %0d expected %0d", at, r + H + 1 + L); end
        n_checks++; if (bus.reset_count !== CW'(exp_count)) begin n_fail++;
            $display("FAIL soft_stable_count: got %0d expected %0d", bus.reset_count,
                     exp_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_power_up();
        test_late_lock();
        test_lock_glitch_stable();
        test_lock_glitch_run();
        test_debounce();
        test_saturation();
`ifdef RESET_SEQ_SOFT_RESET_EN
        test_soft_reset();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
